// File: rtl/median_filter_seq.sv
// median_filter_seq: sliding-window median over a valid/ready sample stream.
// Keeps the last DEPTH unsigned samples; once the window is full, every accepted
// sample triggers DEPTH odd-even transposition passes (one per clock) over a
// copy of the window, followed by a one-cycle Out_valid pulse with the median.
// Optional feature macro: MEDIAN_MINMAX_EN adds Out_min / Out_max outputs.
module median_filter_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         In_valid,
  input  logic [WIDTH-1:0]             In_data,
  output logic                         In_ready,
  input  logic                         Flush,
  output logic                         Out_valid,
  output logic [WIDTH-1:0]             Out_median,
`ifdef MEDIAN_MINMAX_EN
  output logic [WIDTH-1:0]             Out_min,
  output logic [WIDTH-1:0]             Out_max,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   Fill_count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int MID = (DEPTH - 1) / 2;

  // Reject unsupported geometries at elaboration time.
  generate
    if ((DEPTH < 3) || (DEPTH > 9) || ((DEPTH % 2) == 0)) begin : g_bad_depth
      $error("median_filter_seq: DEPTH must be odd and within 3..9");
    end
    if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
      $error("median_filter_seq: WIDTH must be within 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [WIDTH-1:0] med_q, med_d;
  logic [WIDTH-1:0] win_q    [DEPTH];
  logic [WIDTH-1:0] win_d    [DEPTH];
  logic [WIDTH-1:0] win_shift[DEPTH];
  logic [WIDTH-1:0] arr_q    [DEPTH];
  logic [WIDTH-1:0] arr_d    [DEPTH];
  logic [WIDTH-1:0] pass_res [DEPTH];
  logic             accept;

`ifdef MEDIAN_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
`else
  // Build without min/max tracking: only the median register exists.
`endif

  // Flush wins over a simultaneous sample, and samples are only taken in IDLE.
  assign accept = (state_q == IDLE) && In_valid && !Flush;

  // Shifted window: newest sample at index 0, oldest falls off the top.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign win_shift[gi] = In_data;
      end else begin : g_body
        assign win_shift[gi] = win_q[gi-1];
      end
    end
  endgenerate

  // Window update only on an accepted sample.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d = win_shift;
    end
  end

  // One odd-even transposition pass over arr_q. Even passes pair (0,1),(2,3)...,
  // odd passes pair (1,2),(3,4)...; each element takes the min of its pair when it
  // is the lower index and the max when it is the upper one. Equal values are
  // left where they are, which makes the tie case a no-op.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cas
      localparam logic PAR = 1'(gi % 2);
      logic [WIDTH-1:0] lo_v;
      logic [WIDTH-1:0] hi_v;
      if (gi + 1 < DEPTH) begin : g_lo
        assign lo_v = (arr_q[gi+1] < arr_q[gi]) ? arr_q[gi+1] : arr_q[gi];
      end else begin : g_no_lo
        assign lo_v = arr_q[gi];
      end
      if (gi > 0) begin : g_hi
        assign hi_v = (arr_q[gi] < arr_q[gi-1]) ? arr_q[gi-1] : arr_q[gi];
      end else begin : g_no_hi
        assign hi_v = arr_q[gi];
      end
      assign pass_res[gi] = (pass_q[0] == PAR) ? lo_v : hi_v;
    end
  endgenerate

  // Next-state logic for the control FSM, fill counter, sort array and results.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pass_d  = pass_q;
    med_d   = med_q;
    arr_d   = arr_q;
`ifdef MEDIAN_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    case (state_q)
      IDLE: begin
        if (Flush) begin
          fill_d = '0;
        end else if (In_valid) begin
          if (fill_q != CW'(DEPTH)) begin
            fill_d = fill_q + 1'b1;
          end
          // This accept completes (or keeps) a full window: start sorting.
          if (fill_q >= CW'(DEPTH - 1)) begin
            arr_d   = win_d;
            pass_d  = '0;
            state_d = SORT;
          end
        end
      end
      SORT: begin
        arr_d  = pass_res;
        pass_d = pass_q + 1'b1;
        if (pass_q == PW'(DEPTH - 1)) begin
          pass_d  = '0;
          med_d   = pass_res[MID];
`ifdef MEDIAN_MINMAX_EN
          min_d   = pass_res[0];
          max_d   = pass_res[DEPTH-1];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      pass_q  <= '0;
      med_q   <= '0;
`ifdef MEDIAN_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
        arr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pass_q  <= pass_d;
      med_q   <= med_d;
`ifdef MEDIAN_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
      win_q   <= win_d;
      arr_q   <= arr_d;
    end
  end

  // Outputs come straight from registers or the state decode.
  assign In_ready   = (state_q == IDLE);
  assign Out_valid  = (state_q == DONE);
  assign Out_median = med_q;
  assign Fill_count = fill_q;
`ifdef MEDIAN_MINMAX_EN
  assign Out_min    = min_q;
  assign Out_max    = max_q;
`endif

endmodule

// File: tb/tb_median_filter_seq.sv
// tb_median_filter_seq: self-checking bench for median_filter_seq.
// Two instances (DEPTH=3 and DEPTH=5, WIDTH=4) are driven independently; the
// expected medians come from a queue-based window model sorted with .sort().
// Compile with MEDIAN_MINMAX_EN to also check Out_min / Out_max.
module tb_median_filter_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid  [2];
  logic [3:0] in_data   [2];
  logic       flush     [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [3:0] out_median[2];
  logic [1:0] fill3;
  logic [2:0] fill5;
`ifdef MEDIAN_MINMAX_EN
  logic [3:0] out_min[2];
  logic [3:0] out_max[2];
`endif

  int errors = 0;
  int checks = 0;
  int pulses0 = 0;
  int last_med[2];
  int win3[$];
  int win5[$];

  always #5 clk = ~clk;

  median_filter_seq #(.WIDTH(4), .DEPTH(3)) u_dut3 (
    .Clk        (clk),
    .Reset_n    (reset_n),
    .In_valid   (in_valid[0]),
    .In_data    (in_data[0]),
    .In_ready   (in_ready[0]),
    .Flush      (flush[0]),
    .Out_valid  (out_valid[0]),
    .Out_median (out_median[0]),
`ifdef MEDIAN_MINMAX_EN
    .Out_min    (out_min[0]),
    .Out_max    (out_max[0]),
`endif
    .Fill_count (fill3)
  );

  median_filter_seq #(.WIDTH(4), .DEPTH(5)) u_dut5 (
    .Clk        (clk),
    .Reset_n    (reset_n),
    .In_valid   (in_valid[1]),
    .In_data    (in_data[1]),
    .In_ready   (in_ready[1]),
    .Flush      (flush[1]),
    .Out_valid  (out_valid[1]),
    .Out_median (out_median[1]),
`ifdef MEDIAN_MINMAX_EN
    .Out_min    (out_min[1]),
    .Out_max    (out_max[1]),
`endif
    .Fill_count (fill5)
  );

  function automatic int depth_of(input int u);
    return (u == 0) ? 3 : 5;
  endfunction

  function automatic int fill_of(input int u);
    return (u == 0) ? int'(fill3) : int'(fill5);
  endfunction

  // Reference window: append newest, drop oldest beyond DEPTH.
  function automatic void model_push(input int u, input int d);
    if (u == 0) begin
      win3.push_back(d);
      if (win3.size() > 3) void'(win3.pop_front());
    end else begin
      win5.push_back(d);
      if (win5.size() > 5) void'(win5.pop_front());
    end
  endfunction

  function automatic void model_clear(input int u);
    if (u == 0) win3.delete();
    else        win5.delete();
  endfunction

  // Median / min / max of the model window by sorting a copy.
  function automatic void ref_stats(input int u, output int med, output int mn, output int mx);
    int s[$];
    if (u == 0) s = win3;
    else        s = win5;
    s.sort();
    med = s[s.size() / 2];
    mn  = s[0];
    mx  = s[s.size() - 1];
  endfunction

  // Offer one sample and wait (bounded) for the accepting edge.
  task automatic drive_accept(input int u, input int d);
    int n;
    n = 0;
    in_valid[u] = 1'b1;
    in_data[u]  = 4'(d);
    while (!in_ready[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL accept_timeout u=%0d: in_ready=%0d after %0d cycles, required 1", u, in_ready[u], n);
    end
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u]  = 4'($urandom_range(0, 15));
  endtask

  // Accept that leaves the window not yet full: no pulse, stays ready.
  task automatic send_fill(input int u, input int d, input int exp_fill);
    model_push(u, d);
    drive_accept(u, d);
    checks++;
    if (out_valid[u] !== 1'b0) begin
      errors++;
      $display("FAIL fill_no_valid u=%0d: out_valid=%0d required 0", u, out_valid[u]);
    end
    checks++;
    if (fill_of(u) !== exp_fill) begin
      errors++;
      $display("FAIL fill_count u=%0d: got %0d required %0d", u, fill_of(u), exp_fill);
    end
    checks++;
    if (in_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready u=%0d: in_ready=%0d required 1", u, in_ready[u]);
    end
  endtask

  // Accept into a full window and check the resulting median transaction.
  task automatic run_filling(input int u, input int d, input bit flush_in_sort, input bit verbose);
    int med, mn, mx, dep;
    int pulse_n, pulse_idx, ready_idx, got_med, got_min, got_max;
    dep = depth_of(u);
    model_push(u, d);
    ref_stats(u, med, mn, mx);
    drive_accept(u, d);
    pulse_n = 0; pulse_idx = -1; ready_idx = -1;
    got_med = -1; got_min = -1; got_max = -1;
    for (int i = 0; i < 20; i++) begin
      if (flush_in_sort && i == 0) flush[u] = 1'b1;
      if (i == 2) flush[u] = 1'b0;
      if (out_valid[u] === 1'b1) begin
        pulse_n++;
        pulse_idx = i;
        got_med = int'(out_median[u]);
`ifdef MEDIAN_MINMAX_EN
        got_min = int'(out_min[u]);
        got_max = int'(out_max[u]);
`endif
      end
      if (in_ready[u] === 1'b1) begin
        ready_idx = i;
        break;
      end
      @(negedge clk);
    end
    flush[u] = 1'b0;
    if (u == 0) pulses0 += pulse_n;
    last_med[u] = med;
    if (verbose) $display("u=%0d sample=%0d median=%0d expected=%0d", u, d, got_med, med);
    checks++;
    if (pulse_n !== 1) begin
      errors++;
      $display("FAIL pulse_count u=%0d: got %0d pulses required 1", u, pulse_n);
    end
    checks++;
    if (pulse_idx !== dep) begin
      errors++;
      $display("FAIL pulse_latency u=%0d: pulse at cycle %0d required %0d", u, pulse_idx, dep);
    end
    checks++;
    if (got_med !== med) begin
      errors++;
      $display("FAIL median u=%0d sample=%0d: got %0d required %0d", u, d, got_med, med);
    end
    checks++;
    if (ready_idx !== dep + 1) begin
      errors++;
      $display("FAIL ready_return u=%0d: ready at cycle %0d required %0d", u, ready_idx, dep + 1);
    end
    checks++;
    if (fill_of(u) !== dep) begin
      errors++;
      $display("FAIL full_count u=%0d: got %0d required %0d", u, fill_of(u), dep);
    end
`ifdef MEDIAN_MINMAX_EN
    checks++;
    if (got_min !== mn) begin
      errors++;
      $display("FAIL min u=%0d: got %0d required %0d", u, got_min, mn);
    end
    checks++;
    if (got_max !== mx) begin
      errors++;
      $display("FAIL max u=%0d: got %0d required %0d", u, got_max, mx);
    end
`endif
  endtask

  // One-cycle flush in IDLE, optionally with a competing sample offered.
  task automatic do_flush(input int u, input bit with_valid);
    flush[u] = 1'b1;
    if (with_valid) begin
      in_valid[u] = 1'b1;
      in_data[u]  = 4'd15;
    end
    @(negedge clk);
    flush[u]    = 1'b0;
    in_valid[u] = 1'b0;
    model_clear(u);
    checks++;
    if (fill_of(u) !== 0) begin
      errors++;
      $display("FAIL flush_count u=%0d: got %0d required 0", u, fill_of(u));
    end
    checks++;
    if (int'(out_median[u]) !== last_med[u]) begin
      errors++;
      $display("FAIL flush_keeps_median u=%0d: got %0d required %0d", u, out_median[u], last_med[u]);
    end
    checks++;
    if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
      errors++;
      $display("FAIL flush_state u=%0d: ready=%0d valid=%0d required 1/0", u, in_ready[u], out_valid[u]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      in_data[u]  = 4'd0;
      flush[u]    = 1'b0;
      last_med[u] = 0;
      model_clear(u);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_handshake u=%0d: ready=%0d valid=%0d required 1/0", u, in_ready[u], out_valid[u]);
      end
      checks++;
      if (out_median[u] !== 4'd0 || fill_of(u) !== 0) begin
        errors++;
        $display("FAIL reset_values u=%0d: median=%0d fill=%0d required 0/0", u, out_median[u], fill_of(u));
      end
`ifdef MEDIAN_MINMAX_EN
      checks++;
      if (out_min[u] !== 4'd0 || out_max[u] !== 4'd0) begin
        errors++;
        $display("FAIL reset_minmax u=%0d: min=%0d max=%0d required 0/0", u, out_min[u], out_max[u]);
      end
`endif
    end
  endtask

  task automatic test_fill();
    send_fill(0, 5, 1);
    send_fill(0, 1, 2);
    run_filling(0, 9, 1'b0, 1'b1);
  endtask

  task automatic test_sliding();
    run_filling(0, 0, 1'b0, 1'b1);
    run_filling(0, 7, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    do_flush(0, 1'b1);
    send_fill(0, 1, 1);
    send_fill(0, 2, 2);
    run_filling(0, 3, 1'b0, 1'b1);
    run_filling(0, 12, 1'b1, 1'b1);
  endtask

  task automatic test_depth5();
    do_flush(1, 1'b0);
    send_fill(1, 15, 1);
    send_fill(1, 0, 2);
    send_fill(1, 8, 3);
    send_fill(1, 3, 4);
    run_filling(1, 12, 1'b0, 1'b1);
  endtask

  task automatic test_ties();
    do_flush(1, 1'b0);
    send_fill(1, 7, 1);
    send_fill(1, 7, 2);
    send_fill(1, 2, 3);
    send_fill(1, 7, 4);
    run_filling(1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random_stream();
    for (int u = 0; u < 2; u++) begin
      do_flush(u, 1'b0);
      for (int k = 0; k < 30; k++) begin
        if (k < depth_of(u) - 1)
          send_fill(u, int'($urandom_range(0, 15)), k + 1);
        else
          run_filling(u, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      end
    end
  endtask

  task automatic test_exhaustive();
    int start;
    start = pulses0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++) begin
          do_flush(0, 1'b0);
          send_fill(0, a, 1);
          send_fill(0, b, 2);
          run_filling(0, c, 1'b0, 1'b0);
        end
    $display("exhaustive triples done, pulses=%0d", pulses0 - start);
    checks++;
    if (pulses0 - start !== 4096) begin
      errors++;
      $display("FAIL exhaustive_pulses: got %0d required 4096", pulses0 - start);
    end
  endtask

  task automatic test_reset_mid_sort();
    int stray;
    drive_accept(0, 4);          // window is full: SORT pass 0 now pending
    @(negedge clk);              // pass 1 pending
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      model_clear(u);
      last_med[u] = 0;
    end
    checks++;
    if (in_ready[0] !== 1'b1 || fill_of(0) !== 0 || out_median[0] !== 4'd0) begin
      errors++;
      $display("FAIL abort_state: ready=%0d fill=%0d median=%0d required 1/0/0", in_ready[0], fill_of(0), out_median[0]);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0] === 1'b1) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got %0d pulses required 0", stray);
    end
    $display("reset during SORT pass 1 aborted, stray pulses=%0d", stray);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_sliding();
    test_flush();
    test_depth5();
    test_ties();
    test_random_stream();
    test_exhaustive();
    test_reset_mid_sort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
